// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sequences one calculator operation per accepted rdy strobe.
// Add/sub/mul finish in the EXEC cycle; div (and optionally mod) are handed to
// an external multi-cycle divider and guarded by a DIV_TIMEOUT cycle limit.
// Optional feature: define CALC_SEQ_MOD_EN to support cmd 4 (modulo via div_r).
module calc_op_sequencer #(
    parameter int unsigned DIV_TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  op_A,
    input  logic [7:0]  op_B,
    input  logic [3:0]  cmd,
    output logic        div_start,
    output logic [7:0]  div_a,
    output logic [7:0]  div_b,
    input  logic        div_done,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic [15:0] result,
    output logic        res_valid,
    output logic        err,
    output logic        neg,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  dbg_state
);
    // Handshake rules: rdy is a one-cycle strobe accepted only in IDLE (otherwise
    // dropped and recorded in sticky overrun); div_start is a one-cycle pulse with
    // div_a/div_b held until div_done or timeout; div_done counts only in DIV_WAIT;
    // res_valid is a one-cycle strobe qualifying result/err/neg, which then hold.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_MUL = 4'd2;
    localparam logic [3:0] CMD_DIV = 4'd3;
    localparam logic [3:0] CMD_MOD = 4'd4;

    // Counter value seen on the last DIV_WAIT edge before the timeout fires.
    localparam logic [7:0] CNT_LAST = 8'(DIV_TIMEOUT - 1);

`ifdef CALC_SEQ_MOD_EN
    localparam logic MOD_EN = 1'b1;
`else
    localparam logic MOD_EN = 1'b0;
    logic unused_div_r;
    assign unused_div_r = ^div_r;
`endif

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] result_d;
    logic        res_valid_d, err_d, neg_d, overrun_d, div_start_d;
    logic [7:0]  div_a_d, div_b_d;

    logic [8:0]  sum9;
    logic [7:0]  mag8;
    logic [15:0] prod16;
    logic        a_lt_b;

    assign sum9   = {1'b0, a_q} + {1'b0, b_q};
    assign a_lt_b = (a_q < b_q);
    assign mag8   = a_lt_b ? (b_q - a_q) : (a_q - b_q);
    assign prod16 = {8'h00, a_q} * {8'h00, b_q};

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Operand latches, timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            neg       <= 1'b0;
            overrun   <= 1'b0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            result    <= result_d;
            res_valid <= res_valid_d;
            err       <= err_d;
            neg       <= neg_d;
            overrun   <= overrun_d;
            div_start <= div_start_d;
            div_a     <= div_a_d;
            div_b     <= div_b_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        result_d    = result;
        res_valid_d = 1'b0;
        err_d       = err;
        neg_d       = neg;
        overrun_d   = overrun;
        div_start_d = 1'b0;
        div_a_d     = div_a;
        div_b_d     = div_b;

        // Any strobe arriving while not idle is lost; remember that it happened.
        if (rdy && (state_q != IDLE)) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    a_d       = op_A;
                    b_d       = op_B;
                    cmd_d     = cmd;
                    overrun_d = 1'b0;
                    state_d   = EXEC;
                end
            end

            EXEC: begin
                state_d     = IDLE;
                res_valid_d = 1'b1;
                err_d       = 1'b0;
                neg_d       = 1'b0;
                case (cmd_q)
                    CMD_ADD: result_d = {7'b0, sum9};
                    CMD_SUB: begin
                        result_d = {8'h00, mag8};
                        neg_d    = a_lt_b;
                    end
                    CMD_MUL: result_d = prod16;
                    CMD_DIV, CMD_MOD: begin
                        if ((b_q == 8'h00) || ((cmd_q == CMD_MOD) && !MOD_EN)) begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end else begin
                            // Hand off to the divider; result registers keep the old value.
                            res_valid_d = 1'b0;
                            err_d       = err;
                            neg_d       = neg;
                            div_start_d = 1'b1;
                            div_a_d     = a_q;
                            div_b_d     = b_q;
                            cnt_d       = '0;
                            state_d     = DIV_WAIT;
                        end
                    end
                    default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                endcase
            end

            DIV_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (div_done) begin
`ifdef CALC_SEQ_MOD_EN
                    result_d = (cmd_q == CMD_MOD) ? {8'h00, div_r} : {8'h00, div_q};
`else
                    result_d = {8'h00, div_q};
`endif
                    err_d       = 1'b0;
                    neg_d       = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d    = '0;
                    err_d       = 1'b1;
                    neg_d       = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed and randomized checks of calc_op_sequencer
// against a behavioural reference model; the bench also plays the divider.
module tb_calc_op_sequencer;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  op_A = '0, op_B = '0;
    logic [3:0]  cmd = '0;
    logic        div_start;
    logic [7:0]  div_a, div_b;
    logic        div_done = 1'b0;
    logic [7:0]  div_q = '0, div_r = '0;
    logic [15:0] result;
    logic        res_valid, err, neg, busy, overrun;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    logic [15:0] prev_result = '0;
    logic        prev_err = 1'b0;
    logic        prev_neg = 1'b0;

    // Clock generation.
    always #5 clk = ~clk;

    calc_op_sequencer #(.DIV_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .op_A(op_A), .op_B(op_B), .cmd(cmd),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .result(result), .res_valid(res_valid), .err(err), .neg(neg),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the calculator should answer, and whether it needs the divider.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                                  output logic [15:0] r, output logic e, output logic n,
                                  output logic ud);
        r = '0; e = 1'b0; n = 1'b0; ud = 1'b0;
        case (c)
            4'd0: r = 16'(a) + 16'(b);
            4'd1: begin
                if (a >= b) r = 16'(a) - 16'(b);
                else begin r = 16'(b) - 16'(a); n = 1'b1; end
            end
            4'd2: r = 16'(a) * 16'(b);
            4'd3: begin
                if (b == 0) e = 1'b1;
                else begin ud = 1'b1; r = 16'(a) / 16'(b); end
            end
            4'd4: begin
`ifdef CALC_SEQ_MOD_EN
                if (b == 0) e = 1'b1;
                else begin ud = 1'b1; r = 16'(a) % 16'(b); end
`else
                e = 1'b1;
`endif
            end
            default: e = 1'b1;
        endcase
    endfunction

    // One request: d = divider answer delay after div_start (0 = never answers),
    // glitch_j = cycle index of an extra rdy while busy (-1 none),
    // late_j = cycle index of a stray div_done (-1 none).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                          input int d, input int glitch_j, input int late_j, input string name);
        logic [15:0] er;
        logic        ee, en, ud;
        logic [7:0]  qa, ra;
        int          jv, js, jend;
        model(a, b, c, er, ee, en, ud);
        qa = 8'($urandom);
        ra = 8'($urandom);
        if (ud) begin
            qa = a / b;
            ra = a % b;
        end
        js = ud ? 1 : -1;
        if (!ud) jv = 1;
        else if (d > 0) jv = 2 + d;
        else begin jv = 1 + TO; er = '0; ee = 1'b1; en = 1'b0; end
        jend = ((late_j > jv) ? late_j : jv) + 2;

        @(negedge clk);
        rdy = 1'b1; op_A = a; op_B = b; cmd = c;
        for (int j = 0; j <= jend; j++) begin
            @(negedge clk);
            chk1($sformatf("%s res_valid j=%0d", name, j), res_valid, j == jv);
            chk1($sformatf("%s busy j=%0d", name, j), busy, j < jv);
            chk1($sformatf("%s div_start j=%0d", name, j), div_start, j == js);
            chk1($sformatf("%s overrun j=%0d", name, j), overrun, (glitch_j >= 0) && (j > glitch_j));
            chk16($sformatf("%s result j=%0d", name, j), result, (j >= jv) ? er : prev_result);
            chk1($sformatf("%s err j=%0d", name, j), err, (j >= jv) ? ee : prev_err);
            chk1($sformatf("%s neg j=%0d", name, j), neg, (j >= jv) ? en : prev_neg);
            if (ud && (j >= js) && (j < jv)) begin
                chk16($sformatf("%s div_a j=%0d", name, j), {8'h00, div_a}, {8'h00, a});
                chk16($sformatf("%s div_b j=%0d", name, j), {8'h00, div_b}, {8'h00, b});
            end
            rdy = (j == glitch_j);
            if (rdy) begin
                op_A = 8'($urandom);
                op_B = 8'($urandom);
                cmd  = 4'($urandom_range(0, 4));
            end
            div_done = (ud && (d > 0) && (j == 1 + d)) || (j == late_j);
            div_q    = div_done ? qa : 8'($urandom);
            div_r    = div_done ? ra : 8'($urandom);
        end
        rdy = 1'b0;
        div_done = 1'b0;
        prev_result = er;
        prev_err = ee;
        prev_neg = en;
    endtask

    // Asynchronous reset in the middle of a divide, with a glitch and a late completion.
    task automatic reset_mid_div();
        @(negedge clk);
        rdy = 1'b1; op_A = 8'd200; op_B = 8'd3; cmd = 4'd3;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk1("rst_mid busy before", busy, 1'b1);
        chk1("rst_mid overrun before", overrun, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk16("rst_mid result", result, 16'h0000);
        chk1("rst_mid res_valid", res_valid, 1'b0);
        chk1("rst_mid err", err, 1'b0);
        chk1("rst_mid neg", neg, 1'b0);
        chk1("rst_mid busy", busy, 1'b0);
        chk1("rst_mid overrun", overrun, 1'b0);
        chk1("rst_mid div_start", div_start, 1'b0);
        chk16("rst_mid div_a", {8'h00, div_a}, 16'h0000);
        chk16("rst_mid div_b", {8'h00, div_b}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        prev_result = '0; prev_err = 1'b0; prev_neg = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk1($sformatf("rst_mid late res_valid j=%0d", j), res_valid, 1'b0);
            chk1($sformatf("rst_mid late busy j=%0d", j), busy, 1'b0);
            chk16($sformatf("rst_mid late result j=%0d", j), result, 16'h0000);
            div_done = (j == 1);
            div_q = 8'd66;
        end
        div_done = 1'b0;
    endtask

    // Directed steps followed by randomized requests, then the summary.
    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rc;
        #1;
        chk16("reset result", result, 16'h0000);
        chk1("reset res_valid", res_valid, 1'b0);
        chk1("reset err", err, 1'b0);
        chk1("reset neg", neg, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset overrun", overrun, 1'b0);
        chk1("reset div_start", div_start, 1'b0);
        chk16("reset div_a", {8'h00, div_a}, 16'h0000);
        chk16("reset div_b", {8'h00, div_b}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(8'h25, 8'h11, 4'd0, 0, -1, -1, "add");
        run_op(8'd3, 8'd10, 4'd1, 0, -1, -1, "sub_neg");
        run_op(8'd255, 8'd255, 4'd2, 0, -1, -1, "mul_max");
        run_op(8'd100, 8'd7, 4'd3, 5, -1, -1, "div");
        run_op(8'd100, 8'd7, 4'd4, 5, -1, -1, "mod");
        run_op(8'd9, 8'd0, 4'd3, 3, -1, -1, "div_by_zero");
        run_op(8'd5, 8'd5, 4'hA, 0, -1, -1, "bad_cmd");
        run_op(8'd77, 8'd5, 4'd3, 0, -1, TO + 2, "timeout_late_done");
        run_op(8'd77, 8'd5, 4'd3, TO - 1, -1, -1, "done_at_timeout");
        run_op(8'd50, 8'd6, 4'd3, 1, -1, -1, "div_min_latency");
        run_op(8'd100, 8'd7, 4'd3, 4, 2, -1, "overrun_div");
        run_op(8'd1, 8'd2, 4'd0, 0, 0, -1, "overrun_return_edge");
        run_op(8'd4, 8'd4, 4'd1, 0, -1, 1, "sub_equal");

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rc = 4'($urandom_range(0, 5));
            if (rc == 4'd5) rc = 4'($urandom_range(5, 15));
            run_op(ra, rb, rc, $urandom_range(0, TO - 1), -1, -1, $sformatf("rand%0d", i));
        end

        reset_mid_div();
        run_op(8'd200, 8'd100, 4'd0, 0, -1, -1, "add_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Sequencing controller between `cmd_interp` and the calculator arithmetic datapath. It accepts the one-cycle `rdy` strobe with `op_A`, `op_B` and `cmd`, and latches the operands. Add, subtract and multiply are executed in a single registered cycle. Divide (and optional modulo) are dispatched to the shared multi-cycle divider over a start/done handshake, guarded by a timeout. It produces one registered 16-bit result with a valid strobe and error flag for the display path.

## Interface
- `DIV_TIMEOUT`, 31, max cycles spent in DIV_WAIT before the operation is aborted with error (1..255).
- `clk  in  1  system clock, rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `rdy  in  1  one-cycle strobe from cmd_interp; operands/command valid`
- `op_A  in  8  operand A (unsigned)`
- `op_B  in  8  operand B (unsigned)`
- `cmd  in  4  operation: 0 add, 1 sub, 2 mul, 3 div, 4 mod; others invalid`
- `div_start  out  1  one-cycle start pulse to divider`
- `div_a  out  8  dividend, held stable from div_start until done/timeout`
- `div_b  out  8  divisor, held stable likewise`
- `div_done  in  1  one-cycle divider completion strobe`
- `div_q  in  8  quotient, valid with div_done`
- `div_r  in  8  remainder, valid with div_done`
- `result  out  16  registered result`
- `res_valid  out  1  one-cycle strobe: result/err/neg updated`
- `err  out  1  error for current result (div by zero, invalid cmd, timeout)`
- `neg  out  1  subtract result negative`
- `busy  out  1  high whenever state != IDLE`
- `overrun  out  1  sticky: rdy arrived while busy`

## Operation
- States: IDLE, EXEC, DIV_WAIT.
- IDLE + `rdy`: latch op_A/op_B/cmd into internal regs, clear `overrun`, go to EXEC.
- EXEC, per latched cmd:
  - add: result = {7'b0, A+B} (9-bit sum zero-extended), neg=0.
  - sub: A>=B gives result = A−B, neg=0; A<B gives result = B−A (magnitude), neg=1.
  - mul: result = A*B, 16-bit unsigned.
  - div/mod with B==0, or invalid cmd: result=0, err=1, no div_start.
  - In all the above cases: pulse res_valid, go to IDLE.
  - div/mod with B!=0: pulse div_start, drive div_a=A, div_b=B, clear timeout counter, go to DIV_WAIT.
- DIV_WAIT:
  - div_done: result = {8'b0, div_q} (div) or {8'b0, div_r} (mod), err=0, pulse res_valid, go to IDLE.
  - Otherwise increment counter. On reaching DIV_TIMEOUT: result=0, err=1, pulse res_valid, go to IDLE.
- result, err and neg hold their values until the next res_valid. err/neg are cleared on every successful result.
- rdy while busy: request dropped, overrun set. Cleared only on the next accepted rdy or by reset.
- div_done outside DIV_WAIT is ignored, including late completions after a timeout or a reset.

## Timing
- Reset (rst low, async): state IDLE. result=0, res_valid=0, err=0, neg=0, busy=0, overrun=0, div_start=0, div_a=0, div_b=0, counter=0.
- rdy sampled at edge k:
  - Non-div ops and errors detected in EXEC: res_valid high during cycle after edge k+1, for exactly one cycle.
  - div/mod: div_start high during cycle after edge k+1. div_done sampled at edge m gives res_valid in the cycle after edge m.
- Minimum div latency: div_done in the cycle after div_start gives res_valid 2 cycles after div_start.
- Timeout: res_valid/err occur DIV_TIMEOUT cycles after entering DIV_WAIT.
- div_done and timeout in the same cycle: done wins, err=0.
- rdy at the edge where the FSM returns to IDLE (state still EXEC/DIV_WAIT) is dropped and sets overrun. rdy in the next cycle is accepted.
- Back-to-back throughput for ALU ops: one request per 2 cycles.
- Reset mid-DIV_WAIT aborts with no res_valid.

## Configuration
- `CALC_SEQ_MOD_EN` defined: cmd 4 (mod) is supported and returns div_r.
- Not defined: cmd 4 is treated as invalid (err=1 via the EXEC path, no div_start), and div_r is unused.

## Test plan
- Reset release, then rdy with A=8'h25, B=8'h11, cmd=0: result=16'h0036, neg=0, err=0, res_valid exactly 2 edges after rdy.
- Sub with A=3, B=10: result=7, neg=1. Then mul with A=255, B=255: result=16'hFE01, neg=0.
- Div with A=100, B=7, divider model answers done 5 cycles after start with q=14, r=2: result=14, err=0, busy high throughout. With CALC_SEQ_MOD_EN and cmd=4: result=2. Without it, cmd=4 gives err=1 and no div_start.
- Div with B=0: no div_start, err=1, result=0. Cmd=4'hA: err=1.
- DIV_TIMEOUT=8 with a divider that never answers: err=1 and res_valid 8 cycles into DIV_WAIT. A late div_done afterwards causes no res_valid.
- rdy pulsed during DIV_WAIT: overrun=1 and the original result is unaffected. The next accepted rdy clears overrun. Async rst low mid-divide: all outputs 0 immediately, no res_valid.
